// File: rtl/i2c_edge_interval_checker_if.sv
// Event inputs and result outputs of the edge-interval checker.
// Latency: none (wiring only); backpressure: none, the checker only observes.
interface i2c_edge_interval_checker_if #(
    parameter int CNT_W  = 16,
    parameter int VCNT_W = 16
) ();
    logic              s1;
    logic              s2;
    logic [CNT_W-1:0]  lim;
    logic              vio;
    logic              vio_sticky;
    logic [VCNT_W-1:0] vio_cnt;
    logic [CNT_W-1:0]  last_delta;
    logic              armed;

    modport master (
        output s1, s2, lim,
        input  vio, vio_sticky, vio_cnt, last_delta, armed
    );

    modport slave (
        input  s1, s2, lim,
        output vio, vio_sticky, vio_cnt, last_delta, armed
    );
endinterface

// File: rtl/i2c_edge_interval_checker.sv
// Measures cycles from a qualified s1 edge to a qualified s2 edge and flags intervals below lim.
// Latency: results registered one cycle after the s2 edge is sampled; backpressure: none (passive).
module i2c_edge_interval_checker #(
    parameter int E1_MODE = 1,
    parameter int E2_MODE = 1,
    parameter int CNT_W   = 16,
    parameter int VCNT_W  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    i2c_edge_interval_checker_if.slave    bus
);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

    logic              r_s1_q;
    logic              r_s2_q;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_armed;
    logic              r_vio;
    logic              r_vio_sticky;
    logic [VCNT_W-1:0] r_vio_cnt;
    logic [CNT_W-1:0]  r_last_delta;

    logic w_s1_evt;
    logic w_s2_evt;

    // Mode 1 = rising, 2 = falling, anything else = any change.
    function automatic logic sel_evt(input int mode, input logic cur, input logic prev);
        case (mode)
            1:       return cur & ~prev;
            2:       return ~cur & prev;
            default: return cur ^ prev;
        endcase
    endfunction

    always_comb begin
        w_s1_evt = sel_evt(E1_MODE, bus.s1, r_s1_q);
        w_s2_evt = sel_evt(E2_MODE, bus.s2, r_s2_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            // Track the inputs during reset so release never creates a false edge.
            r_s1_q       <= bus.s1;
            r_s2_q       <= bus.s2;
            r_cnt        <= CNT_MAX;
            r_armed      <= 1'b0;
            r_vio        <= 1'b0;
            r_vio_sticky <= 1'b0;
            r_vio_cnt    <= '0;
            r_last_delta <= '0;
        end else begin
            r_s1_q <= bus.s1;
            r_s2_q <= bus.s2;
            r_vio  <= 1'b0;

            // The s2 check uses the pre-update count, so a same-cycle s1 restart never yields 0.
            if (w_s2_evt && r_armed) begin
                r_last_delta <= r_cnt;
                if (r_cnt < bus.lim) begin
                    r_vio        <= 1'b1;
                    r_vio_sticky <= 1'b1;
                    if (r_vio_cnt != VCNT_MAX) begin
                        r_vio_cnt <= r_vio_cnt + VCNT_W'(1);
                    end
                end
            end

            if (w_s1_evt) begin
                r_cnt   <= CNT_W'(1);
                r_armed <= 1'b1;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.vio        = r_vio;
    assign bus.vio_sticky = r_vio_sticky;
    assign bus.vio_cnt    = r_vio_cnt;
    assign bus.last_delta = r_last_delta;
    assign bus.armed      = r_armed;
endmodule

// File: tb/tb_i2c_edge_interval_checker.sv
// Drives EE, EL and LE checker instances from shared s1/s2/lim stimulus and scoreboards
// them against a timestamp-based model of the interval rules.
module tb_i2c_edge_interval_checker;
    localparam int CW   = 8;
    localparam int VW   = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam int VMAX = (1 << VW) - 1;

    typedef struct packed {
        logic          vio;
        logic          sticky;
        logic [VW-1:0] vcnt;
        logic [CW-1:0] ld;
        logic          armed;
    } exp_t;

    typedef struct packed {
        exp_t [2:0] e;
    } trio_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s1  = 1'b0;
    logic          s2  = 1'b0;
    logic [CW-1:0] lim = '0;

    always #5 clk = ~clk;

    i2c_edge_interval_checker_if #(.CNT_W(CW), .VCNT_W(VW)) if0 ();
    i2c_edge_interval_checker_if #(.CNT_W(CW), .VCNT_W(VW)) if1 ();
    i2c_edge_interval_checker_if #(.CNT_W(CW), .VCNT_W(VW)) if2 ();

    assign if0.s1 = s1;  assign if0.s2 = s2;  assign if0.lim = lim;
    assign if1.s1 = s1;  assign if1.s2 = s2;  assign if1.lim = lim;
    assign if2.s1 = s1;  assign if2.s2 = s2;  assign if2.lim = lim;

    i2c_edge_interval_checker #(.E1_MODE(1), .E2_MODE(1), .CNT_W(CW), .VCNT_W(VW))
        u_ee (.i_clk(clk), .i_rst(rst), .bus(if0));
    i2c_edge_interval_checker #(.E1_MODE(1), .E2_MODE(0), .CNT_W(CW), .VCNT_W(VW))
        u_el (.i_clk(clk), .i_rst(rst), .bus(if1));
    i2c_edge_interval_checker #(.E1_MODE(0), .E2_MODE(1), .CNT_W(CW), .VCNT_W(VW))
        u_le (.i_clk(clk), .i_rst(rst), .bus(if2));

    int    checks = 0;
    int    errors = 0;
    trio_t sbq[$];

    // Reference model: timestamps of the last start event, per instance.
    int    mode1[3] = '{1, 1, 0};
    int    mode2[3] = '{1, 0, 1};
    string nm[3]    = '{"ee", "el", "le"};
    logic  prev1 = 1'b0;
    logic  prev2 = 1'b0;
    logic  arm[3];
    int    t_s1[3];
    exp_t  st[3];
    int    ncyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic evt(input int mode, input logic cur, input logic prev);
        if (mode == 1) return cur && !prev;
        if (mode == 2) return !cur && prev;
        return cur != prev;
    endfunction

    task automatic cyc(input logic r, input logic a, input logic b, input int l);
        trio_t t;
        int    d;
        @(negedge clk);
        rst = r;
        s1  = a;
        s2  = b;
        lim = CW'(l);
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                arm[i] = 1'b0;
                st[i]  = '0;
            end else begin
                st[i].vio = 1'b0;
                if (evt(mode2[i], b, prev2) && arm[i]) begin
                    d = ncyc - t_s1[i];
                    if (d > CMAX) d = CMAX;
                    st[i].ld = CW'(d);
                    if (d < int'(lim)) begin
                        st[i].vio    = 1'b1;
                        st[i].sticky = 1'b1;
                        if (int'(st[i].vcnt) < VMAX) st[i].vcnt = st[i].vcnt + VW'(1);
                    end
                end
                if (evt(mode1[i], a, prev1)) begin
                    arm[i]  = 1'b1;
                    t_s1[i] = ncyc;
                end
                st[i].armed = arm[i];
            end
            t.e[i] = st[i];
        end
        prev1 = a;
        prev2 = b;
        ncyc++;
        sbq.push_back(t);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: each cycle's registered outputs against the oldest queued expectation.
    initial begin
        trio_t exp_v;
        trio_t act;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                exp_v = sbq.pop_front();
                act.e[0] = {if0.vio, if0.vio_sticky, if0.vio_cnt, if0.last_delta, if0.armed};
                act.e[1] = {if1.vio, if1.vio_sticky, if1.vio_cnt, if1.last_delta, if1.armed};
                act.e[2] = {if2.vio, if2.vio_sticky, if2.vio_cnt, if2.last_delta, if2.armed};
                for (int i = 0; i < 3; i++)
                    chk({"sb_", nm[i]}, 32'(act.e[i]), 32'(exp_v.e[i]));
            end
        end
    end

    initial begin
        logic a;
        logic b;
        int   lv;
        int   wait_cnt;
        for (int i = 0; i < 3; i++) begin
            arm[i]  = 1'b0;
            t_s1[i] = 0;
            st[i]   = '0;
        end

        repeat (3) cyc(0, 0, 0, 0);
        settle();
        chk("rst_armed", 32'(if0.armed), 0);
        chk("rst_vcnt", 32'(if0.vio_cnt), 0);
        chk("rst_ld", 32'(if0.last_delta), 0);

        // EE, lim 10, s2 five cycles after s1
        cyc(1, 0, 0, 10);
        cyc(1, 1, 0, 10);
        repeat (4) cyc(1, 1, 0, 10);
        cyc(1, 1, 1, 10);
        settle();
        chk("ee5_ld", 32'(if0.last_delta), 5);
        chk("ee5_vio", 32'(if0.vio), 1);
        chk("ee5_vcnt", 32'(if0.vio_cnt), 1);
        chk("ee5_sticky", 32'(if0.vio_sticky), 1);
        cyc(1, 1, 1, 10);
        settle();
        chk("ee5_pulse_end", 32'(if0.vio), 0);

        // EE, lim 10, s2 twelve cycles after s1
        repeat (2) cyc(0, 0, 0, 10);
        cyc(1, 0, 0, 10);
        cyc(1, 1, 0, 10);
        repeat (11) cyc(1, 1, 0, 10);
        cyc(1, 1, 1, 10);
        settle();
        chk("ee12_ld", 32'(if0.last_delta), 12);
        chk("ee12_vio", 32'(if0.vio), 0);
        chk("ee12_vcnt", 32'(if0.vio_cnt), 0);

        // EL, lim 4: s2 falls then rises 3 cycles after s1 rises
        repeat (2) cyc(0, 0, 1, 4);
        cyc(1, 0, 1, 4);
        cyc(1, 1, 1, 4);
        repeat (2) cyc(1, 1, 1, 4);
        cyc(1, 1, 0, 4);
        settle();
        chk("el_fall_ld", 32'(if1.last_delta), 3);
        chk("el_fall_vio", 32'(if1.vio), 1);
        cyc(1, 0, 0, 4);
        cyc(1, 1, 0, 4);
        repeat (2) cyc(1, 1, 0, 4);
        cyc(1, 1, 1, 4);
        settle();
        chk("el_rise_ld", 32'(if1.last_delta), 3);
        chk("el_rise_vcnt", 32'(if1.vio_cnt), 2);

        // LE, lim 4: s1 falls, s2 rises 6 cycles later, then s2 falling ignored
        repeat (2) cyc(0, 1, 0, 4);
        cyc(1, 1, 0, 4);
        cyc(1, 0, 0, 4);
        repeat (5) cyc(1, 0, 0, 4);
        cyc(1, 0, 1, 4);
        settle();
        chk("le_ld", 32'(if2.last_delta), 6);
        chk("le_vio", 32'(if2.vio), 0);
        cyc(1, 0, 0, 4);
        settle();
        chk("le_fall_ignored", 32'(if2.last_delta), 6);

        // Unarmed s2, then simultaneous s1/s2 edges
        repeat (2) cyc(0, 0, 0, 4);
        cyc(1, 0, 0, 4);
        cyc(1, 0, 1, 4);
        settle();
        chk("unarm_armed", 32'(if0.armed), 0);
        chk("unarm_ld", 32'(if0.last_delta), 0);
        chk("unarm_vio", 32'(if0.vio), 0);
        cyc(1, 0, 0, 4);
        cyc(1, 1, 1, 4);
        settle();
        chk("same_armed", 32'(if0.armed), 1);
        chk("same_ld", 32'(if0.last_delta), 0);
        chk("same_vio", 32'(if0.vio), 0);
        cyc(1, 1, 0, 4);
        settle();
        chk("same_cnt1", 32'(if1.last_delta), 1);

        // s1 held high across reset release: no start event
        repeat (2) cyc(0, 1, 0, 4);
        cyc(1, 1, 0, 4);
        cyc(1, 1, 1, 4);
        settle();
        chk("hold_ee_armed", 32'(if0.armed), 0);
        chk("hold_le_armed", 32'(if2.armed), 0);

        // Three violations, then reset clears counters
        cyc(1, 0, 1, 100);
        cyc(1, 1, 1, 100);
        repeat (3) begin
            cyc(1, 1, 0, 100);
            cyc(1, 1, 1, 100);
        end
        settle();
        chk("three_vcnt", 32'(if0.vio_cnt), 3);
        chk("three_sticky", 32'(if0.vio_sticky), 1);
        cyc(0, 1, 1, 100);
        settle();
        chk("clr_vcnt", 32'(if0.vio_cnt), 0);
        chk("clr_sticky", 32'(if0.vio_sticky), 0);

        // Violation counter saturation
        cyc(1, 1, 1, 100);
        cyc(1, 0, 1, 100);
        cyc(1, 1, 1, 100);
        repeat (10) begin
            cyc(1, 1, 0, 100);
            cyc(1, 1, 1, 100);
        end
        settle();
        chk("vcnt_sat", 32'(if0.vio_cnt), VMAX);

        // Interval counter saturation never violates, even at the largest limit
        cyc(1, 0, 0, CMAX);
        cyc(1, 1, 0, CMAX);
        repeat (300) cyc(1, 1, 0, CMAX);
        cyc(1, 1, 1, CMAX);
        settle();
        chk("cnt_sat_ld", 32'(if0.last_delta), CMAX);
        chk("cnt_sat_vio", 32'(if0.vio), 0);

        // Randomized traffic with occasional resets and limit changes
        a  = s1;
        b  = s2;
        lv = 8;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) a = ~a;
            if ($urandom_range(0, 4) == 0) b = ~b;
            if ($urandom_range(0, 15) == 0)
                lv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, CMAX)) : int'($urandom_range(0, 20));
            cyc(($urandom_range(0, 199) != 0), a, b, lv);
        end

        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain left %0d want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_edge_interval_checker.md
Name: i2c_edge_interval_checker

Overview:
- Clocked timing-check monitor for the I2C master bench and debug logic.
- Measures the interval, in clk cycles, from a selected edge on signal s1 to a selected edge on signal s2.
- Flags a violation when that interval is shorter than a run-time limit.
- One block covers the three check flavours via parameters: edge→edge (EE), edge→any-change (EL), any-change→edge (LE).

Parameters:
- E1_MODE, 1, edge qualifier on s1: 0=any change, 1=rising, 2=falling (3 behaves as 0).
- E2_MODE, 1, edge qualifier on s2, same encoding. Settings: EE=(1,1), EL=(1,0), LE=(0,1).
- CNT_W, 16, width of the interval counter, lim and last_delta.
- VCNT_W, 16, width of the violation counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- s1  in  1  start-event signal, already synchronous to clk.
- s2  in  1  end-event signal, already synchronous to clk.
- lim  in  CNT_W  minimum allowed interval in cycles; sampled in the cycle the s2 event is detected.
- vio  out  1  one-cycle violation pulse.
- vio_sticky  out  1  set on any violation; cleared only by reset.
- vio_cnt  out  VCNT_W  saturating violation count.
- last_delta  out  CNT_W  interval measured at the most recent s2 event.
- armed  out  1  an s1 event has occurred since reset.

Behaviour:
- Edge detect: registers s1_q and s2_q hold the previous samples.
  - rise = s & ~s_q; fall = ~s & s_q; any = s ^ s_q.
  - s1_evt and s2_evt are selected per E1_MODE / E2_MODE.
- While rst=0:
  - s1_q←s1 and s2_q←s2, so no spurious edge appears on the first cycle after release.
  - cnt←all-ones; armed←0; vio←0; vio_sticky←0; vio_cnt←0; last_delta←0.
- cnt counts cycles elapsed since the last s1 event:
  - on s1_evt, cnt←1;
  - otherwise cnt←cnt+1, saturating at 2^CNT_W−1.
  - In the cycle k cycles after an s1 event, cnt==k before update.
- On s1_evt: armed←1 (stays 1 until reset).
- On s2_evt with armed=1:
  - last_delta←cnt, using the pre-update value;
  - if cnt < lim: vio←1 for exactly the next cycle, vio_sticky←1, vio_cnt←vio_cnt+1 (saturating at all-ones).
- On s2_evt with armed=0: nothing happens. last_delta and all flags are unchanged.
- s1_evt and s2_evt in the same cycle: s2 is checked against the previous s1 event first (old cnt), then cnt restarts at 1.
  - The same-cycle s1 event never yields delta 0.
  - If not previously armed, that s2 event is ignored.
- Any other cycle: vio←0.
- Back-to-back s2 events each produce an independent check and pulse.
- lim=0 never violates.
- A saturated cnt (2^CNT_W−1) never violates, because lim ≤ 2^CNT_W−1.
- The block is purely passive; it has no effect on s1/s2.
- Outputs are all registered; vio appears one cycle after the s2 edge is sampled.
- Reset asserted mid-measurement discards the pending interval; the block re-arms only on a new s1 event.

Test Plan:
- EE (1,1), lim=10: s1 rises at cycle 0, s2 rises at cycle 5 → last_delta=5, vio pulses 1 cycle, vio_cnt=1, vio_sticky=1.
- EE, lim=10: s1 rises at cycle 0, s2 rises at cycle 12 → last_delta=12, vio stays 0, vio_cnt=0.
- EL (1,0), lim=4: s1 rises, then s2 falls 3 cycles later → violation with delta=3. s2 rising 3 cycles after another s1 rise also violates.
- LE (0,1), lim=4: s1 falls, then s2 rises 6 cycles later → last_delta=6, no violation. s2 falling is ignored.
- After reset with no s1 activity, s2 rises → armed=0, no vio, last_delta=0. Then s1 and s2 both rise in the same cycle → still no check; cnt=1 next cycle.
- Reset: hold s1=1 across reset release → no s1 event on release. Assert rst=0 after 3 violations → vio_cnt=0 and vio_sticky=0 the next cycle.
